// File: rtl/uart_mult_byte_tx.sv
// Packet UART transmitter: latches three parameter fields on pack_start and sends
// the fixed 8-byte frame 55 A B1 B0 C1 C0 0D 0A, 8N1, LSB first, bytes back-to-back.
module uart_mult_byte_tx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int UART_BPS = 230400
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        pack_start,
   input  logic [7:0]  dataA,
   input  logic [15:0] dataB,
   input  logic [15:0] dataC,
   output logic        uart_txd,
   output logic        pack_busy,
   output logic        pack_done,
   output logic [2:0]  byte_cnt
);

   localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
   localparam logic [15:0] CLK_LAST = 16'(BPS_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state, state_next;
   logic [15:0] clk_cnt, clk_cnt_next;
   logic [2:0]  bit_cnt, bit_cnt_next;
   logic [2:0]  byte_cnt_next;
   logic [63:0] shift_reg, shift_next;
   logic        txd_next;
   logic        done_next;
   logic        bit_end;

   assign bit_end   = (clk_cnt == CLK_LAST);
   assign pack_busy = (state != IDLE);

   // uart_txd is registered from the next-state decode so the line changes on the
   // same edge as the state and never glitches.
   always_comb begin
      state_next    = state;
      clk_cnt_next  = clk_cnt;
      bit_cnt_next  = bit_cnt;
      byte_cnt_next = byte_cnt;
      shift_next    = shift_reg;
      txd_next      = uart_txd;
      done_next     = 1'b0;

      if (state != IDLE) begin
         clk_cnt_next = bit_end ? 16'd0 : clk_cnt + 16'd1;
      end

      case (state)
         IDLE: begin
            txd_next = 1'b1;
            if (pack_start) begin
               state_next    = START;
               clk_cnt_next  = 16'd0;
               bit_cnt_next  = 3'd0;
               byte_cnt_next = 3'd0;
               shift_next    = {8'h0A, 8'h0D, dataC[7:0], dataC[15:8],
                                dataB[7:0], dataB[15:8], dataA, 8'h55};
               txd_next      = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_next   = DATA;
               bit_cnt_next = 3'd0;
               txd_next     = shift_reg[0];
            end
         end
         DATA: begin
            // Consume one bit per bit time; after bit 7 the next byte sits in [7:0].
            if (bit_end) begin
               shift_next = shift_reg >> 1;
               if (bit_cnt == 3'd7) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
                  txd_next     = shift_reg[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (byte_cnt == 3'd7) begin
                  state_next    = IDLE;
                  byte_cnt_next = 3'd0;
                  done_next     = 1'b1;
                  txd_next      = 1'b1;
               end else begin
                  state_next    = START;
                  byte_cnt_next = byte_cnt + 3'd1;
                  txd_next      = 1'b0;
               end
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         clk_cnt   <= 16'd0;
         bit_cnt   <= 3'd0;
         byte_cnt  <= 3'd0;
         shift_reg <= 64'd0;
         uart_txd  <= 1'b1;
         pack_done <= 1'b0;
      end else begin
         state     <= state_next;
         clk_cnt   <= clk_cnt_next;
         bit_cnt   <= bit_cnt_next;
         byte_cnt  <= byte_cnt_next;
         shift_reg <= shift_next;
         uart_txd  <= txd_next;
         pack_done <= done_next;
      end
   end

endmodule
